signal_tracker: RTL and testbench

//  Records a timestamped history of one input signal in a circular buffer and answers two queries

---
 rtl/signal_tracker_pkg.sv | 31 +++
 rtl/signal_history_ram.sv | 42 ++++
 rtl/signal_tracker.sv | 220 ++++++++++++++++++++++
 tb/tb_signal_tracker.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_tracker_pkg.sv
// Shared types and constants for signal_tracker.
//   NO_MATCH       : time_out value reported when the window holds no high sample
//   engine_state_e : states used by the time engine (IDLE/SCAN/DONE) and
//                    the value engine (IDLE/READ/DONE)
//   recall_src_e   : where the value engine takes its answer from
//   clamp_window   : min(max(w, 0), limit) on signed 32-bit values
package signal_tracker_pkg;

  localparam logic signed [31:0] NO_MATCH = -32'sd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } engine_state_e;

  typedef enum logic [1:0] {
    SRC_LIVE = 2'd0,  // N <= 0: value present on the capture edge
    SRC_HIST = 2'd1,  // 1 <= N <= fill: history entry at age N
    SRC_ZERO = 2'd2   // N > fill: nothing recorded that far back
  } recall_src_e;

  function automatic logic signed [31:0] clamp_window(input logic signed [31:0] w,
                                                      input logic signed [31:0] limit);
    if (w <= 0) return 32'sd0;
    if (w > limit) return limit;
    return w;
  endfunction

endpackage

// File: rtl/signal_history_ram.sv
// History storage: DEPTH x WIDTH block RAM, one write port and two
// independent synchronous read ports (one per query engine).
// A read of the address being written on the same edge returns the old
// contents, which the time engine relies on when its window spans the
// whole buffer.
// Ports:
//   clk                     clock
//   wr_en_i/wr_addr_i/wr_data_i   write port
//   rd_a_en_i/rd_a_addr_i -> rd_a_data_o   read port A (registered, held when not enabled)
//   rd_b_en_i/rd_b_addr_i -> rd_b_data_o   read port B (registered, held when not enabled)
module signal_history_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 33,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_a_en_i,
  input  logic [AW-1:0]    rd_a_addr_i,
  output logic [WIDTH-1:0] rd_a_data_o,
  input  logic             rd_b_en_i,
  input  logic [AW-1:0]    rd_b_addr_i,
  output logic [WIDTH-1:0] rd_b_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rd_a_en_i) rd_a_data_o <= mem[rd_a_addr_i];
  end

  always_ff @(posedge clk) begin
    if (rd_b_en_i) rd_b_data_o <= mem[rd_b_addr_i];
  end

endmodule

// File: rtl/signal_tracker.sv
// Records {counter, signal_in} every cycle into a circular history and
// answers two queries against it:
//   time engine  : oldest timestamp within the last W cycles where
//                  signal_in[0] was high (NO_MATCH if none)
//   value engine : signal_in value N cycles back
// Ports:
//   clk, rst_n (synchronous, active-low)
//   counter                 timestamp stored with each sample
//   signal_in               tracked signal
//   recalculate_time/value_in        -> time_out, time_valid
//   recalculate_back_cycle/cycles_back_to_recall -> signal_recall, recall_valid
module signal_tracker
  import signal_tracker_pkg::*;
#(
  parameter int DATA_WIDTH  = 1,
  parameter int BUFFER_SIZE = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [31:0]     counter,
  input  logic [DATA_WIDTH-1:0]  signal_in,
  input  logic                   recalculate_time,
  input  logic signed [31:0]     value_in,
  output logic signed [31:0]     time_out,
  output logic                   time_valid,
  input  logic                   recalculate_back_cycle,
  input  logic signed [31:0]     cycles_back_to_recall,
  output logic [DATA_WIDTH-1:0]  signal_recall,
  output logic                   recall_valid
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int EW = 32 + DATA_WIDTH;
  localparam logic [AW:0] FILL_MAX = (AW+1)'(BUFFER_SIZE);
  localparam logic [AW:0] AGE_ONE  = (AW+1)'(1);

  // ---------------- recording ----------------
  logic [AW-1:0]        wr_ptr_q;
  logic [AW:0]          fill_q;
  logic signed [31:0]   fill_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fill_q != FILL_MAX) fill_q <= fill_q + 1'b1;
    end
  end

  assign fill_s = 32'(fill_q);

  logic          t_rd_en, v_rd_en;
  logic [AW-1:0] t_rd_addr, v_rd_addr;
  logic [EW-1:0] t_rd_data, v_rd_data;

  signal_history_ram #(.DEPTH(BUFFER_SIZE), .WIDTH(EW)) u_ram (
    .clk         (clk),
    .wr_en_i     (rst_n),
    .wr_addr_i   (wr_ptr_q),
    .wr_data_i   ({counter, signal_in}),
    .rd_a_en_i   (t_rd_en),
    .rd_a_addr_i (t_rd_addr),
    .rd_a_data_o (t_rd_data),
    .rd_b_en_i   (v_rd_en),
    .rd_b_addr_i (v_rd_addr),
    .rd_b_data_o (v_rd_data)
  );

  // ---------------- time engine ----------------
  // The oldest entry (age L) is read on the capture edge itself, so each
  // SCAN cycle checks one entry while fetching the next younger one.
  engine_state_e      t_state_q, t_state_d;
  logic [AW-1:0]      t_snap_q, t_snap_d;
  logic [AW:0]        t_age_q, t_age_d, t_age_dec;
  logic signed [31:0] time_out_q, time_out_d;
  logic signed [31:0] t_len;

  assign t_len     = clamp_window(value_in, fill_s);
  assign t_age_dec = t_age_q - 1'b1;

  always_comb begin
    t_state_d  = t_state_q;
    t_snap_d   = t_snap_q;
    t_age_d    = t_age_q;
    time_out_d = time_out_q;
    t_rd_en    = 1'b0;
    t_rd_addr  = '0;
    case (t_state_q)
      IDLE: begin
        if (recalculate_time) begin
          t_snap_d = wr_ptr_q;
          if (t_len == 32'sd0) begin
            time_out_d = NO_MATCH;
            t_state_d  = DONE;
          end else begin
            t_age_d   = t_len[AW:0];
            t_rd_en   = 1'b1;
            t_rd_addr = wr_ptr_q - t_len[AW-1:0];
            t_state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (t_rd_data[0]) begin
          time_out_d = t_rd_data[EW-1:DATA_WIDTH];
          t_state_d  = DONE;
        end else if (t_age_q == AGE_ONE) begin
          time_out_d = NO_MATCH;
          t_state_d  = DONE;
        end else begin
          t_age_d   = t_age_dec;
          t_rd_en   = 1'b1;
          t_rd_addr = t_snap_q - t_age_dec[AW-1:0];
        end
      end
      DONE: begin
        if (!recalculate_time) t_state_d = IDLE;
      end
      default: t_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_state_q  <= IDLE;
      t_snap_q   <= '0;
      t_age_q    <= '0;
      time_out_q <= NO_MATCH;
    end else begin
      t_state_q  <= t_state_d;
      t_snap_q   <= t_snap_d;
      t_age_q    <= t_age_d;
      time_out_q <= time_out_d;
    end
  end

  assign time_out   = time_out_q;
  assign time_valid = (t_state_q == DONE);

  // ---------------- value engine ----------------
  // The history read is issued on the capture edge (so an entry about to be
  // overwritten is still returned); READ then lasts two cycles so the answer
  // appears exactly two edges after capture.
  engine_state_e          v_state_q, v_state_d;
  recall_src_e            v_sel_q, v_sel_d;
  logic                   v_wait_q, v_wait_d;
  logic [DATA_WIDTH-1:0]  v_live_q, v_live_d;
  logic [DATA_WIDTH-1:0]  recall_q, recall_d;

  always_comb begin
    v_state_d = v_state_q;
    v_sel_d   = v_sel_q;
    v_wait_d  = v_wait_q;
    v_live_d  = v_live_q;
    recall_d  = recall_q;
    v_rd_en   = 1'b0;
    v_rd_addr = '0;
    case (v_state_q)
      IDLE: begin
        if (recalculate_back_cycle) begin
          v_live_d  = signal_in;
          v_wait_d  = 1'b0;
          v_state_d = READ;
          if (cycles_back_to_recall <= 32'sd0) begin
            v_sel_d = SRC_LIVE;
          end else if (cycles_back_to_recall > fill_s) begin
            v_sel_d = SRC_ZERO;
          end else begin
            v_sel_d   = SRC_HIST;
            v_rd_en   = 1'b1;
            v_rd_addr = wr_ptr_q - cycles_back_to_recall[AW-1:0];
          end
        end
      end
      READ: begin
        if (!v_wait_q) begin
          v_wait_d = 1'b1;
        end else begin
          case (v_sel_q)
            SRC_LIVE: recall_d = v_live_q;
            SRC_HIST: recall_d = v_rd_data[DATA_WIDTH-1:0];
            default:  recall_d = '0;
          endcase
          v_state_d = DONE;
        end
      end
      DONE: begin
        if (!recalculate_back_cycle) v_state_d = IDLE;
      end
      default: v_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_state_q <= IDLE;
      v_sel_q   <= SRC_ZERO;
      v_wait_q  <= 1'b0;
      v_live_q  <= '0;
      recall_q  <= '0;
    end else begin
      v_state_q <= v_state_d;
      v_sel_q   <= v_sel_d;
      v_wait_q  <= v_wait_d;
      v_live_q  <= v_live_d;
      recall_q  <= recall_d;
    end
  end

  assign signal_recall = recall_q;
  assign recall_valid  = (v_state_q == DONE);

  // Timestamp bits are not needed by the value engine; data bits above
  // bit 0 are not needed by the time engine.
  logic rd_unused;
  assign rd_unused = ^{v_rd_data[EW-1:DATA_WIDTH], t_rd_data[DATA_WIDTH-1:0]};

endmodule

// File: tb/tb_signal_tracker.sv
// Scoreboard bench for signal_tracker: expected answers come from a
// bench-side history queue when each request is driven, and are popped and
// compared when the matching valid rises. Spec scenarios additionally get
// fixed-constant checks.
module tb_signal_tracker;
  localparam int DW = 32;
  localparam int BS = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic signed [31:0]   counter;
  logic [DW-1:0]        signal_in;
  logic                 recalculate_time;
  logic signed [31:0]   value_in;
  logic signed [31:0]   time_out;
  logic                 time_valid;
  logic                 recalculate_back_cycle;
  logic signed [31:0]   cycles_back_to_recall;
  logic [DW-1:0]        signal_recall;
  logic                 recall_valid;

  signal_tracker #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .counter                (counter),
    .signal_in              (signal_in),
    .recalculate_time       (recalculate_time),
    .value_in               (value_in),
    .time_out               (time_out),
    .time_valid             (time_valid),
    .recalculate_back_cycle (recalculate_back_cycle),
    .cycles_back_to_recall  (cycles_back_to_recall),
    .signal_recall          (signal_recall),
    .recall_valid           (recall_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          ts;
    logic [DW-1:0] val;
  } entry_t;

  entry_t hist[$];
  longint exp_time_q[$];
  longint exp_recall_q[$];
  int     mode;
  int     pulse_a;
  int     pulse_b;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int c);
    logic [DW-1:0] v;
    case (mode)
      0: v = (c == pulse_a || c == pulse_b) ? DW'(1) : {DW{1'b0}};
      1: v = DW'(c * 4);
      default: begin
        v = DW'($urandom);
        v[0] = ($urandom_range(0, 15) == 0);
      end
    endcase
    return v;
  endfunction

  // One clock edge: record what the DUT samples, then drive the next cycle.
  task automatic tick();
    entry_t e;
    @(posedge clk);
    if (rst_n) begin
      e.ts  = counter;
      e.val = signal_in;
      hist.push_back(e);
      if (hist.size() > BS) void'(hist.pop_front());
    end else begin
      hist.delete();
    end
    #1;
    counter   = counter + 1;
    signal_in = pattern(counter);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n     = 1'b1;
    counter   = 0;
    signal_in = pattern(0);
  endtask

  task automatic run_to(input int c);
    while (counter < c) tick();
  endtask

  function automatic int win_len(input int w);
    int fill;
    fill = hist.size();
    return (w <= 0) ? 0 : ((w > fill) ? fill : w);
  endfunction

  function automatic longint model_time(input int w);
    int fill;
    int l;
    fill = hist.size();
    l = win_len(w);
    for (int k = l; k >= 1; k--)
      if (hist[fill-k].val[0]) return longint'(hist[fill-k].ts);
    return -1;
  endfunction

  function automatic longint model_recall(input int n);
    int fill;
    fill = hist.size();
    if (n <= 0) return longint'(signal_in);
    if (n <= fill) return longint'(hist[fill-n].val);
    return 0;
  endfunction

  task automatic query(input bit do_t, input int w, input bit do_v, input int n,
                       input int hold, output longint t_got, output longint v_got);
    int     l, t_lat, v_lat;
    bit     t_done, v_done;
    longint t_exp, v_exp;
    l = win_len(w);
    t_got = -2; v_got = -2; t_lat = -1; v_lat = -1; t_exp = 0; v_exp = 0;
    if (do_t) begin
      exp_time_q.push_back(model_time(w));
      recalculate_time = 1'b1;
      value_in = w;
    end
    if (do_v) begin
      exp_recall_q.push_back(model_recall(n));
      recalculate_back_cycle = 1'b1;
      cycles_back_to_recall = n;
    end
    t_done = !do_t;
    v_done = !do_v;
    for (int i = 0; i < BS + 8 && !(t_done && v_done); i++) begin
      tick();
      if (i == 0) begin
        // parameters after capture must be ignored
        value_in = $urandom_range(0, 5);
        cycles_back_to_recall = $urandom_range(0, 5);
      end
      if (!t_done && time_valid) begin
        t_done = 1'b1; t_lat = i;
        t_exp = exp_time_q.pop_front();
        t_got = longint'(time_out);
        chk("time_out", t_got, t_exp);
        chk("time_latency_within_L+2", longint'(i <= l + 2), 1);
      end
      if (!v_done && recall_valid) begin
        v_done = 1'b1; v_lat = i;
        v_exp = exp_recall_q.pop_front();
        v_got = longint'(signal_recall);
        chk("signal_recall", v_got, v_exp);
        chk("recall_latency", i, 2);
      end
    end
    if (!t_done) begin
      chk("time_valid_timeout", time_valid, 1);
      if (exp_time_q.size() > 0) void'(exp_time_q.pop_front());
    end
    if (!v_done) begin
      chk("recall_valid_timeout", recall_valid, 1);
      if (exp_recall_q.size() > 0) void'(exp_recall_q.pop_front());
    end
    repeat (hold) begin
      tick();
      if (do_t) begin
        chk("time_valid_hold", time_valid, 1);
        chk("time_out_hold", longint'(time_out), t_exp);
      end
      if (do_v) begin
        chk("recall_valid_hold", recall_valid, 1);
        chk("signal_recall_hold", longint'(signal_recall), v_exp);
      end
    end
    recalculate_time = 1'b0;
    recalculate_back_cycle = 1'b0;
    tick();
    if (do_t) chk("time_valid_drop", time_valid, 0);
    if (do_v) chk("recall_valid_drop", recall_valid, 0);
    $display("txn: time(req=%0b W=%0d) -> %0d lat %0d | recall(req=%0b N=%0d) -> %0d lat %0d",
             do_t, w, t_got, t_lat, do_v, n, v_got, v_lat);
  endtask

  initial begin
    longint tg, vg;
    rst_n = 1'b0; counter = 0; signal_in = '0;
    recalculate_time = 1'b0; value_in = 0;
    recalculate_back_cycle = 1'b0; cycles_back_to_recall = 0;
    mode = 0; pulse_a = 10; pulse_b = 14;

    // reset state
    do_reset();
    chk("reset_time_out", longint'(time_out), -1);
    chk("reset_time_valid", time_valid, 0);
    chk("reset_signal_recall", longint'(signal_recall), 0);
    chk("reset_recall_valid", recall_valid, 0);

    // 1: pulses at 10 and 14, request at 20, W=15
    run_to(20);
    query(1, 15, 0, 0, 0, tg, vg);
    chk("s1_oldest_pulse", tg, 10);

    // 2: never high
    pulse_a = -1; pulse_b = -1;
    do_reset();
    run_to(30);
    query(1, 8, 0, 0, 0, tg, vg);
    chk("s2_no_pulse", tg, -1);
    query(1, 0, 0, 0, 0, tg, vg);
    chk("s2_zero_window", tg, -1);
    query(1, -5, 0, 0, 0, tg, vg);

    // 3: signal = counter*4
    mode = 1;
    do_reset();
    run_to(50);
    query(0, 0, 1, 3, 0, tg, vg);
    chk("s3_recall_n3", vg, 188);
    do_reset();
    run_to(50);
    query(0, 0, 1, 0, 0, tg, vg);
    chk("s3_recall_n0", vg, 200);
    query(0, 0, 1, 1000, 0, tg, vg);
    chk("s3_recall_beyond_fill", vg, 0);
    query(0, 0, 1, -3, 0, tg, vg);

    // 5: concurrent requests, held past valid
    mode = 2;
    do_reset();
    run_to(60);
    query(1, 40, 1, 7, 3, tg, vg);

    // random concurrent queries across a wrapped buffer
    run_to(400);
    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 20)) tick();
      query(1, $urandom_range(0, 305) - 5, 1, $urandom_range(0, 303) - 3,
            $urandom_range(0, 2), tg, vg);
    end

    // 4: wrap, pulse overwritten vs retained
    mode = 0; pulse_a = 30; pulse_b = -1;
    do_reset();
    run_to(300);
    query(1, 300, 0, 0, 0, tg, vg);
    chk("s4_pulse_overwritten", tg, -1);
    pulse_a = 100;
    do_reset();
    run_to(300);
    query(1, 300, 1, 256, 0, tg, vg);
    chk("s4_pulse_retained", tg, 100);

    // 6: reset during SCAN
    pulse_a = -1;
    do_reset();
    run_to(100);
    recalculate_time = 1'b1;
    value_in = 80;
    repeat (5) tick();
    chk("s6_scanning_not_valid", time_valid, 0);
    rst_n = 1'b0;
    tick();
    chk("s6_reset_time_valid", time_valid, 0);
    chk("s6_reset_time_out", longint'(time_out), -1);
    recalculate_time = 1'b0;
    rst_n = 1'b1;
    counter = 0;
    signal_in = pattern(0);
    query(1, 5, 1, 4, 0, tg, vg);
    chk("s6_empty_time", tg, -1);
    chk("s6_empty_recall", vg, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
